bell_round_ctrl: RTL and testbench

- Parametrised N-player successor to the two-player bell/score path.
- Runs one bell round: latches the face-up cards, arbitrates the first bell press, judges it against the target-sum rule, and updates per-player signed scores.
- Flags match end when one player leads every other player by more than a margin.
- Sits between the keypad decoder (bell_req) and the LCD/score display logic.

---
 rtl/bell_pkg.sv | 34 +++
 rtl/bell_arbiter.sv | 44 ++++
 rtl/bell_round_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_bell_round_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bell_pkg.sv
// rtl/bell_pkg.sv - shared state codes, default constants and saturating add for the bell round controller
package bell_pkg;

    typedef logic [2:0] bell_state_t;

    localparam bell_state_t IDLE  = 3'd0;
    localparam bell_state_t ARMED = 3'd1;
    localparam bell_state_t JUDGE = 3'd2;
    localparam bell_state_t AWARD = 3'd3;
    localparam bell_state_t HOLD  = 3'd4;

    localparam int TARGET_DEFAULT      = 5;
    localparam int LEAD_MARGIN_DEFAULT = 50;

    // Adds two signed values and clamps the result to the signed range of sw bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int sw);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (sw - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (sw - 1));
        if (s > hi) begin
            return hi[31:0];
        end else if (s < lo) begin
            return lo[31:0];
        end else begin
            return s[31:0];
        end
    endfunction

endpackage

// File: rtl/bell_arbiter.sv
// rtl/bell_arbiter.sv - picks one press from the rising-edge vector; BELL_RR_PRIORITY_EN selects round-robin priority
module bell_arbiter #(
    parameter int NP = 4,
    parameter int IW = $clog2(NP)
) (
    input  logic [NP-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

`ifdef BELL_RR_PRIORITY_EN
    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        int p;
        valid = 1'b0;
        idx   = '0;
        p     = 0;
        for (int k = 0; k < NP; k++) begin
            p = (int'(ptr) + k) % NP;
            if (!valid && req[p]) begin
                valid = 1'b1;
                idx   = IW'(p);
            end
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest requester as winner.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/bell_round_ctrl.sv
// rtl/bell_round_ctrl.sv - N-player bell round FSM, judge, saturating scores and match end; BELL_RR_PRIORITY_EN enables round-robin press arbitration
module bell_round_ctrl
    import bell_pkg::*;
#(
    parameter int NP          = 4,
    parameter int SW          = 8,
    parameter int NW          = 3,
    parameter int CW          = 2,
    parameter int TARGET      = TARGET_DEFAULT,
    parameter int LEAD_MARGIN = LEAD_MARGIN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   round_start,
    input  logic [NP*CW-1:0]       card_color,
    input  logic [NP*NW-1:0]       card_num,
    input  logic [SW-1:0]          pot,
    input  logic [NP-1:0]          bell_req,
    output logic                   busy,
    output logic                   round_done,
    output logic [$clog2(NP)-1:0]  press_id,
    output logic                   judged_right,
    output logic [NP*SW-1:0]       score,
    output logic                   match_over,
    output logic [$clog2(NP)-1:0]  match_winner
);

    localparam int IW   = $clog2(NP);
    localparam int NC   = 1 << CW;
    localparam int SUMW = NW + IW;

    bell_state_t             state;
    logic [NP-1:0]           prev_req;
    logic [CW-1:0]           col_l [NP];
    logic [NW-1:0]           num_l [NP];
    logic [SW-1:0]           pot_l;
    logic [IW-1:0]           press_id_r;
    logic                    right_r;
    logic                    done_r;
    logic signed [SW-1:0]    score_r [NP];
    logic                    over_r;
    logic [IW-1:0]           winner_r;

    logic [NP-1:0]           rise;
    logic                    arb_valid;
    logic [IW-1:0]           arb_idx;
    logic [IW-1:0]           arb_ptr;
    logic                    right_c;
    logic                    lead_found;
    logic [IW-1:0]           lead_idx;

    // A press is a low-to-high transition, so requests held over from before ARMED never count.
    assign rise = bell_req & ~prev_req;

    bell_arbiter #(.NP(NP), .IW(IW)) u_arb (
        .req   (rise),
        .ptr   (arb_ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

`ifdef BELL_RR_PRIORITY_EN
    logic [IW-1:0] rr_ptr;

    // Round-robin pointer moves just past the last winner once the round is scored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (state == AWARD) begin
            rr_ptr <= (press_id_r == IW'(NP - 1)) ? '0 : press_id_r + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr;
`else
    assign arb_ptr = '0;
`endif

    // Per-colour sums of the latched cards; the press is right if any colour hits the target.
    always_comb begin
        logic [SUMW-1:0] csum [NC];
        right_c = 1'b0;
        for (int c = 0; c < NC; c++) begin
            csum[c] = '0;
        end
        for (int i = 0; i < NP; i++) begin
            csum[col_l[i]] = csum[col_l[i]] + SUMW'(num_l[i]);
        end
        for (int c = 0; c < NC; c++) begin
            if (int'(csum[c]) == TARGET) begin
                right_c = 1'b1;
            end
        end
    end

    // Find a player whose lead over every other player exceeds the margin.
    always_comb begin
        logic ok;
        logic signed [SW:0] d;
        lead_found = 1'b0;
        lead_idx   = '0;
        ok         = 1'b0;
        d          = '0;
        for (int j = NP - 1; j >= 0; j--) begin
            ok = 1'b1;
            for (int m = 0; m < NP; m++) begin
                d = (SW + 1)'(score_r[j]) - (SW + 1)'(score_r[m]);
                if (m != j && !(int'(d) > LEAD_MARGIN)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                lead_found = 1'b1;
                lead_idx   = IW'(j);
            end
        end
    end

    // Round FSM: latch cards, take the press, judge it, pulse done, wait for all bells released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            prev_req   <= '0;
            pot_l      <= '0;
            press_id_r <= '0;
            right_r    <= 1'b0;
            done_r     <= 1'b0;
            for (int i = 0; i < NP; i++) begin
                col_l[i] <= '0;
                num_l[i] <= '0;
            end
        end else begin
            prev_req <= bell_req;
            done_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (round_start && !over_r) begin
                        for (int i = 0; i < NP; i++) begin
                            col_l[i] <= card_color[i*CW +: CW];
                            num_l[i] <= card_num[i*NW +: NW];
                        end
                        pot_l <= pot;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (arb_valid) begin
                        press_id_r <= arb_idx;
                        state      <= JUDGE;
                    end
                end
                JUDGE: begin
                    right_r <= right_c;
                    state   <= AWARD;
                end
                AWARD: begin
                    done_r <= 1'b1;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (bell_req == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Score update: pot to a right presser, otherwise the presser pays NP-1 spread one to each rival.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NP; i++) begin
                score_r[i] <= '0;
            end
        end else if (state == AWARD) begin
            for (int i = 0; i < NP; i++) begin
                if (right_r) begin
                    if (IW'(i) == press_id_r) begin
                        score_r[i] <= SW'(sat_add(32'(score_r[i]), 32'(pot_l), SW));
                    end
                end else if (IW'(i) == press_id_r) begin
                    score_r[i] <= SW'(sat_add(32'(score_r[i]), -(NP - 1), SW));
                end else begin
                    score_r[i] <= SW'(sat_add(32'(score_r[i]), 32'sd1, SW));
                end
            end
        end
    end

    // Match end is sampled one cycle after the scores settle and then held until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            over_r   <= 1'b0;
            winner_r <= '0;
        end else if (!over_r && lead_found) begin
            over_r   <= 1'b1;
            winner_r <= lead_idx;
        end
    end

    // Flatten the score registers onto the output bus.
    always_comb begin
        score = '0;
        for (int i = 0; i < NP; i++) begin
            score[i*SW +: SW] = score_r[i];
        end
    end

    assign busy         = (state != IDLE);
    assign round_done   = done_r;
    assign press_id     = press_id_r;
    assign judged_right = right_r;
    assign match_over   = over_r;
    assign match_winner = winner_r;

endmodule

// File: tb/tb_bell_round_ctrl.sv
// tb/tb_bell_round_ctrl.sv - randomized and directed bench for bell_round_ctrl against a behavioural score model
module tb_bell_round_ctrl;

    localparam int NP = 4;
    localparam int SW = 8;
    localparam int NW = 3;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              round_start;
    logic [NP*CW-1:0]  card_color;
    logic [NP*NW-1:0]  card_num;
    logic [SW-1:0]     pot;
    logic [NP-1:0]     bell_req;
    logic              busy;
    logic              round_done;
    logic [1:0]        press_id;
    logic              judged_right;
    logic [NP*SW-1:0]  score;
    logic              match_over;
    logic [1:0]        match_winner;

    always #5 clk = ~clk;

    bell_round_ctrl #(.NP(NP), .SW(SW), .NW(NW), .CW(CW), .TARGET(5), .LEAD_MARGIN(50)) dut (
        .clk          (clk),
        .rst          (rst),
        .round_start  (round_start),
        .card_color   (card_color),
        .card_num     (card_num),
        .pot          (pot),
        .bell_req     (bell_req),
        .busy         (busy),
        .round_done   (round_done),
        .press_id     (press_id),
        .judged_right (judged_right),
        .score        (score),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    int vecs = 0;
    int errs = 0;

    int m_col [NP];
    int m_num [NP];
    int m_pot;
    int m_score [NP];
    bit m_over;
    int m_win;
    int m_ptr;

    task automatic check_val(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_over = 0;
        m_win  = 0;
        m_ptr  = 0;
    endtask

    task automatic check_scores(input string tag);
        for (int i = 0; i < NP; i++) begin
            check_val($sformatf("%s_score%0d", tag, i), int'($signed(score[i*SW +: SW])), m_score[i]);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        round_start = 1'b0;
        bell_req    = '0;
        step();
        step();
        rst = 1'b1;
        model_reset();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", round_done, 0);
        check_val("rst_press_id", press_id, 0);
        check_val("rst_right", judged_right, 0);
        check_val("rst_over", match_over, 0);
        check_val("rst_winner", match_winner, 0);
        check_scores("rst");
    endtask

    task automatic start_round(input logic [NP*CW-1:0] cols, input logic [NP*NW-1:0] nums, input int p);
        card_color  = cols;
        card_num    = nums;
        pot         = SW'(p);
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        if (!m_over) begin
            for (int i = 0; i < NP; i++) begin
                m_col[i] = int'(cols[i*CW +: CW]);
                m_num[i] = int'(nums[i*NW +: NW]);
            end
            m_pot = p;
        end
        check_val("start_busy", busy, m_over ? 0 : 1);
    endtask

    task automatic press(input logic [NP-1:0] mask);
        int id;
        int sums [4];
        bit right;
        bit found;
        bell_req = mask;
        step();
        check_val("done_edge_k", round_done, 0);
        step();
        check_val("done_edge_k1", round_done, 0);
        step();
        id    = 0;
        found = 0;
`ifdef BELL_RR_PRIORITY_EN
        for (int k = 0; k < NP; k++) begin
            if (!found && mask[(m_ptr + k) % NP]) begin
                found = 1;
                id    = (m_ptr + k) % NP;
            end
        end
`else
        for (int k = 0; k < NP; k++) begin
            if (!found && mask[k]) begin
                found = 1;
                id    = k;
            end
        end
`endif
        m_ptr = (id + 1) % NP;
        for (int c = 0; c < 4; c++) sums[c] = 0;
        for (int i = 0; i < NP; i++) sums[m_col[i]] += m_num[i];
        right = 0;
        for (int c = 0; c < 4; c++) if (sums[c] == 5) right = 1;
        for (int i = 0; i < NP; i++) begin
            if (right) begin
                if (i == id) m_score[i] = clamp(m_score[i] + m_pot);
            end else if (i == id) begin
                m_score[i] = clamp(m_score[i] - (NP - 1));
            end else begin
                m_score[i] = clamp(m_score[i] + 1);
            end
        end
        check_val("round_done", round_done, 1);
        check_val("press_id", press_id, id);
        check_val("judged_right", judged_right, right);
        check_scores("award");
        bell_req = '0;
        step();
        if (!m_over) begin
            for (int j = 0; j < NP; j++) begin
                bit ok;
                ok = 1;
                for (int m = 0; m < NP; m++) begin
                    if (m != j && !(m_score[j] - m_score[m] > 50)) ok = 0;
                end
                if (ok && !m_over) begin
                    m_over = 1;
                    m_win  = j;
                end
            end
        end
        check_val("done_clear", round_done, 0);
        check_val("busy_end", busy, 0);
        check_val("match_over", match_over, m_over);
        if (m_over) check_val("match_winner", match_winner, m_win);
    endtask

    initial begin
        card_color = '0;
        card_num   = '0;
        pot        = '0;
        do_reset();

        // Colour 0 sums to 2+3=5: P2 right, gains pot 6.
        start_round({2'd2, 2'd1, 2'd0, 2'd0}, {3'd1, 3'd4, 3'd3, 3'd2}, 6);
        press(4'b0100);

        // No colour sums to 5: P1 wrong.
        start_round({2'd3, 2'd2, 2'd1, 2'd0}, {3'd4, 3'd3, 3'd2, 3'd1}, 6);
        press(4'b0010);

        // Single press by P0, then P0 and P3 together.
        start_round({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 2);
        press(4'b0001);
        start_round({2'd1, 2'd1, 2'd0, 2'd0}, {3'd1, 3'd1, 3'd3, 3'd3}, 3);
        press(4'b1001);

        // P1 holds across round_start; round_start in ARMED with different cards is ignored.
        bell_req = 4'b0010;
        step();
        start_round({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd2, 3'd3}, 4);
        for (int n = 0; n < 3; n++) begin
            step();
            check_val("held_busy", busy, 1);
            check_val("held_done", round_done, 0);
        end
        card_color  = {2'd3, 2'd2, 2'd1, 2'd0};
        card_num    = {3'd7, 3'd7, 3'd7, 3'd7};
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        check_val("armed_start_busy", busy, 1);
        bell_req = '0;
        step();
        press(4'b0010);

        // Reset while judging aborts the round.
        start_round({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 9);
        bell_req = 4'b0100;
        step();
        rst      = 1'b0;
        bell_req = '0;
        step();
        rst = 1'b1;
        model_reset();
        check_val("judge_rst_busy", busy, 0);
        check_val("judge_rst_done", round_done, 0);
        check_scores("judge_rst");
        step();
        check_val("judge_rst_done2", round_done, 0);

        // Random rounds with small pots.
        for (int r = 0; r < 24; r++) begin
            logic [NP*CW-1:0] cols;
            logic [NP*NW-1:0] nums;
            logic [NP-1:0]    mask;
            cols = NP*CW'($urandom);
            nums = NP*NW'($urandom);
            mask = NP'($urandom_range(1, 15));
            if (r % 3 == 0) begin
                cols = '0;
                nums = {3'd0, 3'd1, 3'd0, 3'd4};
            end
            start_round(cols, nums, $urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) step();
            if (!m_over) press(mask);
        end

        // Lead of exactly 50 is not enough; next right press saturates at 127 and ends the match.
        do_reset();
        start_round({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 50);
        press(4'b0001);
        start_round({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 127);
        press(4'b0001);
        start_round({2'd0, 2'd0, 2'd0, 2'd0}, {3'd0, 3'd0, 3'd0, 3'd5}, 5);
        step();
        check_val("over_idle_busy", busy, 0);
        check_val("over_sticky", match_over, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
